// File: rtl/gate_sweep_controller_if.sv
// ---------------------------------------------------------------------------
// gate_sweep_controller_if
// Bundles the handshake and gate-pin signals between the sweep controller and
// whatever drives/observes it.
//   start      : request one full sweep (into the controller)
//   e          : output of the gate under test (into the controller)
//   a,b,c,d    : gate input pins, a is the MSB of the vector index
//   busy       : sweep in progress
//   done       : one-cycle sweep-complete pulse
//   pass       : last completed sweep had no mismatches
//   err_count  : mismatch count of the current or last sweep (0..16)
//   fail_map   : per-vector mismatch flags, present only when the macro
//                GATE_SWEEP_FAIL_MAP_EN is defined
// Modports: master = stimulus/gate side, slave = controller side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface gate_sweep_controller_if;
   logic       start;
   logic       e;
   logic       a;
   logic       b;
   logic       c;
   logic       d;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] err_count;
`ifdef GATE_SWEEP_FAIL_MAP_EN
   logic [15:0] fail_map;

   modport master (
      output start, e,
      input  a, b, c, d, busy, done, pass, err_count, fail_map
   );

   modport slave (
      input  start, e,
      output a, b, c, d, busy, done, pass, err_count, fail_map
   );
`else
   modport master (
      output start, e,
      input  a, b, c, d, busy, done, pass, err_count
   );

   modport slave (
      input  start, e,
      output a, b, c, d, busy, done, pass, err_count
   );
`endif
endinterface

// File: rtl/gate_sweep_controller.sv
// ---------------------------------------------------------------------------
// gate_sweep_controller
// Sweeps a 4-input gate through all sixteen input vectors (0000..1111),
// holds each vector for SETTLE_CYCLES cycles, samples the gate output for one
// cycle and compares it against the matching bit of EXPECT.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : gate_sweep_controller_if.slave (start, e, a..d, busy, done, pass,
//          err_count and, optionally, fail_map)
// Parameters:
//   SETTLE_CYCLES : settle time per vector, 1..255
//   EXPECT        : expected gate output, bit i for vector index {a,b,c,d}=i
// Optional feature: define GATE_SWEEP_FAIL_MAP_EN to add the fail_map
// register recording which vectors mismatched.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module gate_sweep_controller #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [15:0] EXPECT        = 16'h7FFF
) (
   input logic                    clk,
   input logic                    rst,
   gate_sweep_controller_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] vectorIndex_q, vectorIndex_d;
   logic [7:0] settleCount_q, settleCount_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [4:0] errCount_q, errCount_d;
   logic       mismatch;
`ifdef GATE_SWEEP_FAIL_MAP_EN
   logic [15:0] failMap_q, failMap_d;
`endif

   // Next-state and next-output logic. Every output is computed here and
   // registered below, so the gate pins and status flags come straight off
   // flops and never glitch. Everything holds by default; done is the only
   // flag that defaults low so it stays a single-cycle pulse.
   always_comb begin
      state_d       = state_q;
      vectorIndex_d = vectorIndex_q;
      settleCount_d = settleCount_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      pass_d        = pass_q;
      errCount_d    = errCount_q;
`ifdef GATE_SWEEP_FAIL_MAP_EN
      failMap_d     = failMap_q;
`endif
      mismatch      = (bus.e != EXPECT[vectorIndex_q]);

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d       = SETTLE;
               vectorIndex_d = 4'd0;
               settleCount_d = 8'd0;
               busy_d        = 1'b1;
               pass_d        = 1'b0;
               errCount_d    = 5'd0;
`ifdef GATE_SWEEP_FAIL_MAP_EN
               failMap_d     = 16'h0000;
`endif
            end
         end

         SETTLE: begin
            settleCount_d = settleCount_q + 8'd1;
            if (settleCount_q == SettleLast) begin
               state_d = SAMPLE;
            end
         end

         SAMPLE: begin
            if (mismatch) begin
               errCount_d = (errCount_q == 5'd16) ? 5'd16 : errCount_q + 5'd1;
`ifdef GATE_SWEEP_FAIL_MAP_EN
               failMap_d[vectorIndex_q] = 1'b1;
`endif
            end
            if (vectorIndex_q == 4'd15) begin
               state_d       = DONE;
               vectorIndex_d = 4'd0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               pass_d        = (errCount_d == 5'd0);
            end else begin
               state_d       = SETTLE;
               vectorIndex_d = vectorIndex_q + 4'd1;
               settleCount_d = 8'd0;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset wins over everything, including an
   // in-progress sweep, and clears the status so no done pulse is produced
   // for an aborted sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         vectorIndex_q <= 4'd0;
         settleCount_q <= 8'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         errCount_q    <= 5'd0;
`ifdef GATE_SWEEP_FAIL_MAP_EN
         failMap_q     <= 16'h0000;
`endif
      end else begin
         state_q       <= state_d;
         vectorIndex_q <= vectorIndex_d;
         settleCount_q <= settleCount_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         errCount_q    <= errCount_d;
`ifdef GATE_SWEEP_FAIL_MAP_EN
         failMap_q     <= failMap_d;
`endif
      end
   end

   // The vector index doubles as the gate input pattern, a being the MSB.
   assign bus.a         = vectorIndex_q[3];
   assign bus.b         = vectorIndex_q[2];
   assign bus.c         = vectorIndex_q[1];
   assign bus.d         = vectorIndex_q[0];
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = errCount_q;
`ifdef GATE_SWEEP_FAIL_MAP_EN
   assign bus.fail_map  = failMap_q;
`endif

endmodule

// File: doc/gate_sweep_controller.md
GATE_SWEEP_CONTROLLER -- requirements
Module: gate_sweep_controller

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, SHALL set the number of cycles each input vector is held before sampling; legal range 1..255.
REQ-002 Parameter EXPECT, default 16'h7FFF, SHALL hold the expected gate output per vector index; bit i is the expected output for index i = {a,b,c,d}, with a as MSB.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL request one full sweep.
REQ-006 e  input  1  SHALL carry the output of the gate under control.
REQ-007 a, b, c, d  output  1 each  SHALL drive the gate inputs.
REQ-008 busy  output  1  SHALL indicate that a sweep is in progress.
REQ-009 done  output  1  SHALL be a one-cycle sweep-complete pulse.
REQ-010 pass  output  1  SHALL be high when the last completed sweep had zero mismatches.
REQ-011 err_count  output  5  SHALL give the mismatch count of the current or last sweep, range 0..16.

Function
REQ-012 The FSM SHALL use the states IDLE, SETTLE, SAMPLE and DONE.
REQ-013 In IDLE, start=1 sampled at edge k SHALL produce the following at edge k+1: busy=1, {a,b,c,d}=4'b0000, err_count=0, pass=0, settle counter=0, state=SETTLE.
REQ-014 In SETTLE, the counter SHALL increment each cycle; after SETTLE_CYCLES cycles in SETTLE, the FSM SHALL move to SAMPLE.
REQ-015 In SAMPLE (one cycle), e SHALL be compared with EXPECT[{a,b,c,d}], and err_count SHALL increment by 1 on a mismatch.
REQ-016 After SAMPLE with index < 15, the index SHALL increment by 1, the new vector SHALL be driven, the counter SHALL clear, and the FSM SHALL return to SETTLE.
REQ-017 After SAMPLE with index 15, the FSM SHALL enter DONE. DONE SHALL last one cycle with done=1, busy=0, pass=(final err_count==0), and {a,b,c,d}=0000; the FSM SHALL then go to IDLE.
REQ-018 Sweep order SHALL be 0000 to 1111 ascending; each vector SHALL occupy exactly SETTLE_CYCLES+1 cycles.
REQ-019 done SHALL assert at edge k+1+16*(SETTLE_CYCLES+1); with the default parameters this is k+81.
REQ-020 start SHALL be ignored while busy=1 and in DONE; it SHALL be honoured only in IDLE.
REQ-021 start held high continuously SHALL launch back-to-back sweeps, with one IDLE cycle between done and the next busy.
REQ-022 err_count SHALL NOT wrap: 16 mismatches SHALL yield 5'd16.
REQ-023 pass and err_count SHALL hold their values in IDLE until the next accepted start.
REQ-024 a, b, c and d SHALL change only on clk edges and SHALL be glitch-free registered outputs.

Reset
REQ-025 rst=1 at any edge SHALL force the following, overriding start and any in-progress sweep: state=IDLE, a=b=c=d=0, busy=0, done=0, pass=0, err_count=0, index=0, counter=0.
REQ-026 Reset mid-sweep SHALL abort the sweep without asserting done; a subsequent start SHALL begin again from vector 0000.

Configuration
REQ-027 With macro GATE_SWEEP_FAIL_MAP_EN defined, a 16-bit output fail_map SHALL exist. fail_map SHALL clear on reset and on an accepted start, and bit i SHALL set in SAMPLE when vector i mismatches.
REQ-028 Without GATE_SWEEP_FAIL_MAP_EN, the fail_map port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Correct NAND model on e, defaults, start pulse at k -> done at k+81, pass=1, err_count=0, fail_map=16'h0000.
REQ-030 e stuck at 1 -> err_count=1, pass=0, fail_map=16'h8000.
REQ-031 e stuck at 0 -> err_count=15, pass=0, fail_map=16'h7FFF.
REQ-032 AND-gate model on e -> err_count=16, pass=0, fail_map=16'hFFFF.
REQ-033 rst asserted at vector 0110 mid-SETTLE -> next cycle all outputs 0 and no done; restart -> full sweep from 0000.
REQ-034 start re-pulsed at vector 0101 -> ignored, done still at k+81; with SETTLE_CYCLES=1 -> done at k+33.
